// File: rtl/bp_weight_scheduler_if.sv
// Handshake and data bundle between the epoch scheduler and the network datapath/control.
// The master modport is the driving side (control plus datapath); the scheduler uses slave.
interface bp_weight_scheduler_if #(
  parameter int NUM_W   = 8,
  parameter int W_WIDTH = 8
);
  logic                       en_i;
  logic                       init_i;
  logic                       f_end_i;
  logic                       bp_done_i;
  logic [W_WIDTH-1:0]         bp_w_i;
  logic                       fwd_start_o;
  logic                       zero_loss_o;
  logic                       bp_start_o;
  logic [$clog2(NUM_W)-1:0]   bp_sel_o;
  logic [W_WIDTH-1:0]         bp_w_o;
  logic [NUM_W*W_WIDTH-1:0]   weights_o;
  logic [3:0]                 epoch_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;

  modport master (
    output en_i, init_i, f_end_i, bp_done_i, bp_w_i,
    input  fwd_start_o, zero_loss_o, bp_start_o, bp_sel_o, bp_w_o,
           weights_o, epoch_o, busy_o, done_o, err_o
  );

  modport slave (
    input  en_i, init_i, f_end_i, bp_done_i, bp_w_i,
    output fwd_start_o, zero_loss_o, bp_start_o, bp_sel_o, bp_w_o,
           weights_o, epoch_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/bp_weight_scheduler.sv
// Epoch sequencer for the 4-8-1 net: forward pass, then one shared backprop unit stepped over
// every hidden-to-output weight. It also owns the weight file.
//   state       | meaning
//   S_IDLE      | waiting for init_i
//   S_FWD       | fwd_start_o pulse
//   S_FWD_WAIT  | waiting for f_end_i (watchdog running)
//   S_BP_ISSUE  | bp_start_o pulse for weight idx
//   S_BP_WAIT   | waiting for bp_done_i, then commit weight idx (watchdog running)
//   S_EPOCH_END | zero_loss_o pulse, epoch count advance
//   S_DONE      | all epochs run, waiting for init_i to drop
module bp_weight_scheduler #(
  parameter int NUM_W   = 8,
  parameter int W_WIDTH = 8,
  parameter int EPOCHS  = 16,
  parameter int TIMEOUT = 255
) (
  input logic                   clk_i,
  input logic                   rst_i,
  bp_weight_scheduler_if.slave  bus
);
  localparam int IW  = $clog2(NUM_W);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_FWD_WAIT, S_BP_ISSUE, S_BP_WAIT, S_EPOCH_END, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3:0]         epoch_q, epoch_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               err_q, err_d;
  logic [W_WIDTH-1:0] weight_q [NUM_W];
  logic [W_WIDTH-1:0] weight_d [NUM_W];
  logic [4:0]         epoch_inc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      epoch_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_W; k++) weight_q[k] <= W_WIDTH'(k + 1);
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
      weight_q <= weight_d;
    end
  end

  // Watchdog is a down-counter loaded on entry to a wait state; expiry at zero.
  // A same-cycle bp_done_i is checked first so a late completion still commits.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    epoch_d   = epoch_q;
    wd_d      = wd_q;
    err_d     = err_q;
    weight_d  = weight_q;
    epoch_inc = {1'b0, epoch_q} + 5'd1;
    if (bus.en_i) begin
      case (state_q)
        S_IDLE: if (bus.init_i) begin
          state_d = S_FWD;
          idx_d   = '0;
          epoch_d = '0;
          err_d   = 1'b0;
        end
        S_FWD: begin
          state_d = S_FWD_WAIT;
          wd_d    = WDW'(TIMEOUT - 1);
        end
        S_FWD_WAIT: begin
          if (bus.f_end_i) begin
            state_d = S_BP_ISSUE;
            idx_d   = '0;
          end else if (wd_q == '0) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q - 1'b1;
          end
        end
        S_BP_ISSUE: begin
          state_d = S_BP_WAIT;
          wd_d    = WDW'(TIMEOUT - 1);
        end
        S_BP_WAIT: begin
          if (bus.bp_done_i) begin
            weight_d[idx_q] = bus.bp_w_i;
            if (idx_q == IW'(NUM_W - 1)) begin
              state_d = S_EPOCH_END;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_BP_ISSUE;
            end
          end else if (wd_q == '0) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q - 1'b1;
          end
        end
        S_EPOCH_END: begin
          epoch_d = epoch_inc[3:0];
          state_d = (epoch_inc == 5'(EPOCHS)) ? S_DONE : S_FWD;
        end
        S_DONE: if (!bus.init_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.fwd_start_o = bus.en_i && (state_q == S_FWD);
  assign bus.bp_start_o  = bus.en_i && (state_q == S_BP_ISSUE);
  assign bus.zero_loss_o = bus.en_i && (state_q == S_EPOCH_END);
  assign bus.busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.err_o       = err_q;
  assign bus.epoch_o     = epoch_q;
  assign bus.bp_sel_o    = idx_q;
  assign bus.bp_w_o      = weight_q[idx_q];

  always_comb begin
    bus.weights_o = '0;
    for (int k = 0; k < NUM_W; k++) bus.weights_o[k*W_WIDTH +: W_WIDTH] = weight_q[k];
  end
endmodule
